// File: rtl/proc_mem_pkg.sv
// Shared types and constants for the processor memory path: the request
// controller FSM, the requester owner tag and the memory geometry.
package proc_mem_pkg;

  localparam int ADDR_W     = 16;
  localparam int MEM_AW     = 5;
  localparam int DEPTH      = 32;
  localparam int DATA_W     = 16;
  localparam int STARVE_LIM = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_req_arb.sv
// Fetch/data arbiter: data has priority unless fetch has been passed over
// STARVE_LIM consecutive times, in which case fetch is forced through.
module mem_req_arb #(
  parameter int STARVE_LIM = proc_mem_pkg::STARVE_LIM
) (
  input  logic clk,
  input  logic proc_rst,
  input  logic idle,
  input  logic if_req_valid,
  input  logic d_req_valid,
  output logic if_grant,
  output logic d_grant
);

  localparam int CW = $clog2(STARVE_LIM + 1);

  logic [CW-1:0] starve_cnt;
  logic          force_if;

  always_comb begin
    force_if = if_req_valid && (starve_cnt == CW'(STARVE_LIM));
    d_grant  = idle && d_req_valid && !force_if;
    if_grant = idle && if_req_valid && !d_grant;
  end

  // Counts data grants that fetch sat through; any gap in fetch demand resets it.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      starve_cnt <= '0;
    end else if (!if_req_valid || if_grant) begin
      starve_cnt <= '0;
    end else if (d_grant && (starve_cnt != CW'(STARVE_LIM))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory-side request controller: arbitrates fetch vs load/store, range-checks
// the address, drives the active-low strobes and returns a one-cycle response.
module mem_req_ctrl #(
  parameter int ADDR_W     = proc_mem_pkg::ADDR_W,
  parameter int MEM_AW     = proc_mem_pkg::MEM_AW,
  parameter int DEPTH      = proc_mem_pkg::DEPTH,
  parameter int STARVE_LIM = proc_mem_pkg::STARVE_LIM
) (
  input  logic                clk,
  input  logic                proc_rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [15:0]         if_rsp_data,
  output logic                if_rsp_err,
  input  logic                d_req_valid,
  input  logic                d_req_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [15:0]         d_wdata,
  output logic                d_req_ready,
  output logic                d_rsp_valid,
  output logic [15:0]         d_rsp_data,
  output logic                d_rsp_err,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [15:0]         mem_in,
  output logic                mem_write,
  output logic                mem_read,
  input  logic [15:0]         mem_out,
  output proc_mem_pkg::state_e state_dbg
);

  import proc_mem_pkg::*;

  // Handshake: a request is taken at a rising edge where valid && ready; ready
  // is combinational, only in IDLE and only for the winner. Responses are
  // unconditional one-cycle pulses (no back-pressure on the response side).

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                we_q, we_d;
  logic                if_grant, d_grant;
  logic [ADDR_W-1:0]   req_addr;
  logic [MEM_AW-1:0]   mem_addr_d;
  logic [15:0]         mem_in_d;
  logic                mem_write_d, mem_read_d;
  logic                if_rsp_valid_d, if_rsp_err_d;
  logic                d_rsp_valid_d, d_rsp_err_d;
  logic [15:0]         if_rsp_data_d, d_rsp_data_d;

  mem_req_arb #(.STARVE_LIM(STARVE_LIM)) u_arb (
    .clk          (clk),
    .proc_rst     (proc_rst),
    .idle         (state_q == IDLE),
    .if_req_valid (if_req_valid),
    .d_req_valid  (d_req_valid),
    .if_grant     (if_grant),
    .d_grant      (d_grant)
  );

  assign if_req_ready = if_grant;
  assign d_req_ready  = d_grant;
  assign state_dbg    = state_q;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    we_d           = we_q;
    mem_addr_d     = mem_addr;
    mem_in_d       = mem_in;
    mem_write_d    = 1'b1;
    mem_read_d     = 1'b1;
    if_rsp_valid_d = 1'b0;
    if_rsp_err_d   = 1'b0;
    if_rsp_data_d  = if_rsp_data;
    d_rsp_valid_d  = 1'b0;
    d_rsp_err_d    = 1'b0;
    d_rsp_data_d   = d_rsp_data;
    req_addr       = d_grant ? d_addr : if_addr;

    unique case (state_q)
      IDLE: begin
        if (if_grant || d_grant) begin
          owner_d = d_grant ? OWN_D : OWN_IF;
          we_d    = d_grant && d_req_we;
          if (req_addr >= ADDR_W'(DEPTH)) begin
            state_d = ERR;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = req_addr[MEM_AW-1:0];
            mem_in_d   = d_wdata;
            // Strobes are registered so they are low for exactly one period.
            if (d_grant && d_req_we) mem_write_d = 1'b0;
            else                     mem_read_d  = 1'b0;
          end
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (owner_q == OWN_D) begin
          d_rsp_valid_d = 1'b1;
          d_rsp_data_d  = we_q ? 16'h0000 : mem_out;
        end else begin
          if_rsp_valid_d = 1'b1;
          if_rsp_data_d  = mem_out;
        end
      end
      ERR: begin
        state_d = IDLE;
        if (owner_q == OWN_D) begin
          d_rsp_valid_d = 1'b1;
          d_rsp_err_d   = 1'b1;
          d_rsp_data_d  = 16'h0000;
        end else begin
          if_rsp_valid_d = 1'b1;
          if_rsp_err_d   = 1'b1;
          if_rsp_data_d  = 16'h0000;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      mem_addr     <= '0;
      mem_in       <= '0;
      mem_write    <= 1'b1;
      mem_read     <= 1'b1;
      if_rsp_valid <= 1'b0;
      if_rsp_err   <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_err    <= 1'b0;
      d_rsp_data   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      mem_addr     <= mem_addr_d;
      mem_in       <= mem_in_d;
      mem_write    <= mem_write_d;
      mem_read     <= mem_read_d;
      if_rsp_valid <= if_rsp_valid_d;
      if_rsp_err   <= if_rsp_err_d;
      if_rsp_data  <= if_rsp_data_d;
      d_rsp_valid  <= d_rsp_valid_d;
      d_rsp_err    <= d_rsp_err_d;
      d_rsp_data   <= d_rsp_data_d;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a 32x16 falling-edge memory model.
module tb_mem_req_ctrl;
  import proc_mem_pkg::*;

  logic        clk = 1'b0;
  logic        proc_rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [15:0] if_addr, if_rsp_data;
  logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid, d_rsp_err;
  logic [15:0] d_addr, d_wdata, d_rsp_data;
  logic [4:0]  mem_addr;
  logic [15:0] mem_in, mem_out;
  logic        mem_write, mem_read;
  state_e      state_dbg;

  int          n_vec = 0;
  int          n_err = 0;
  int          both_low = 0;
  int          both_ready = 0;
  logic [15:0] mem [0:31];
  logic        exp_q [$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_req_ctrl dut (
    .clk(clk), .proc_rst(proc_rst),
    .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .d_rsp_err(d_rsp_err), .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_write(mem_write), .mem_read(mem_read), .mem_out(mem_out),
    .state_dbg(state_dbg)
  );

  // Memory model: accesses happen on the falling edge of a strobed cycle.
  always @(negedge clk) begin
    if (proc_rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h0000;
      mem[0]  <= 16'h02F0;
      mem_out <= 16'h0000;
    end else begin
      if (!mem_write) mem[mem_addr] <= mem_in;
      if (!mem_read)  mem_out <= mem[mem_addr];
      if (!mem_write && !mem_read) both_low++;
      if (if_req_ready && d_req_ready) both_ready++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic req(input string tag, input bit is_if, input logic we,
                     input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [1:0] exp_strb, input logic [15:0] exp_data,
                     input logic exp_err);
    int n;
    logic [4:0] a5;
    a5 = addr[4:0];
    @(negedge clk);
    if (is_if) begin
      if_req_valid = 1'b1; if_addr = addr;
    end else begin
      d_req_valid = 1'b1; d_req_we = we; d_addr = addr; d_wdata = wdata;
    end
    #1;
    n = 0;
    while (!(is_if ? if_req_ready : d_req_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_ready"}, 16'(n < 20), 16'd1);
    @(posedge clk); #1;
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    chk({tag, "_strobe"}, 16'({mem_write, mem_read}), 16'(exp_strb));
    chk({tag, "_state"}, 16'(state_dbg), (exp_strb == 2'b11) ? 16'(ERR) : 16'(ACCESS));
    if (exp_strb != 2'b11) chk({tag, "_maddr"}, 16'(mem_addr), 16'(a5));
    if (exp_strb == 2'b01) chk({tag, "_min"}, mem_in, wdata);
    @(posedge clk); #1;
    chk({tag, "_strobe_off"}, 16'({mem_write, mem_read}), 16'h3);
    chk({tag, "_rvalid"}, 16'(is_if ? if_rsp_valid : d_rsp_valid), 16'd1);
    chk({tag, "_other_rvalid"}, 16'(is_if ? d_rsp_valid : if_rsp_valid), 16'd0);
    chk({tag, "_rdata"}, is_if ? if_rsp_data : d_rsp_data, exp_data);
    chk({tag, "_rerr"}, 16'(is_if ? if_rsp_err : d_rsp_err), 16'(exp_err));
    @(posedge clk); #1;
    chk({tag, "_rvalid_drop"}, 16'({if_rsp_valid, d_rsp_valid}), 16'h0);
    chk({tag, "_rdata_hold"}, is_if ? if_rsp_data : d_rsp_data, exp_data);
  endtask

  task automatic contention();
    int ngr, cyc;
    exp_q = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 16'h0000;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_addr = 16'h0003;
    ngr = 0; cyc = 0;
    while (ngr < 8 && cyc < 60) begin
      #1;
      if (if_req_ready || d_req_ready) begin
        chk($sformatf("grant%0d", ngr), 16'(d_req_ready), 16'(exp_q.pop_front()));
        ngr++;
      end
      @(negedge clk); cyc++;
    end
    chk("grant_count", 16'(ngr), 16'd8);
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    proc_rst = 1'b1;
    if_req_valid = 1'b0; if_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", 16'({mem_write, mem_read}), 16'h3);
    chk("rst_maddr", 16'(mem_addr), 16'h0);
    chk("rst_min", mem_in, 16'h0);
    chk("rst_rvalid", 16'({if_rsp_valid, d_rsp_valid, if_rsp_err, d_rsp_err}), 16'h0);
    chk("rst_rdata", if_rsp_data | d_rsp_data, 16'h0);
    chk("rst_ready", 16'({if_req_ready, d_req_ready}), 16'h0);
    chk("rst_state", 16'(state_dbg), 16'(IDLE));
    @(negedge clk);
    proc_rst = 1'b0;

    req("store3",  1'b0, 1'b1, 16'h0003, 16'hBEEF, 2'b01, 16'h0000, 1'b0);
    req("load3",   1'b0, 1'b0, 16'h0003, 16'h0000, 2'b10, 16'hBEEF, 1'b0);
    req("fetch0",  1'b1, 1'b0, 16'h0000, 16'h0000, 2'b10, 16'h02F0, 1'b0);
    req("store31", 1'b0, 1'b1, 16'h001F, 16'h1234, 2'b01, 16'h0000, 1'b0);
    req("fetch31", 1'b1, 1'b0, 16'h001F, 16'h0000, 2'b10, 16'h1234, 1'b0);
    req("load_oor",  1'b0, 1'b0, 16'h0020, 16'h0000, 2'b11, 16'h0000, 1'b1);
    req("store_oor", 1'b0, 1'b1, 16'hFFFF, 16'h5555, 2'b11, 16'h0000, 1'b1);
    req("fetch_oor", 1'b1, 1'b0, 16'h0025, 16'h0000, 2'b11, 16'h0000, 1'b1);
    req("load31",  1'b0, 1'b0, 16'h001F, 16'h0000, 2'b10, 16'h1234, 1'b0);

    contention();

    // Reset in the middle of an access: no response, strobes released.
    begin
      int n;
      @(negedge clk);
      d_req_valid = 1'b1; d_req_we = 1'b0; d_addr = 16'h0003;
      #1;
      n = 0;
      while (!d_req_ready && n < 20) begin @(negedge clk); #1; n++; end
      chk("midrst_ready", 16'(n < 20), 16'd1);
      @(posedge clk); #1;
      d_req_valid = 1'b0;
      chk("midrst_in_access", 16'({mem_write, mem_read}), 16'h2);
      proc_rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_strobes", 16'({mem_write, mem_read}), 16'h3);
      chk("midrst_rvalid", 16'({if_rsp_valid, d_rsp_valid}), 16'h0);
      chk("midrst_state", 16'(state_dbg), 16'(IDLE));
      @(negedge clk);
      proc_rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_rvalid2", 16'({if_rsp_valid, d_rsp_valid}), 16'h0);
    end

    chk("strobes_both_low", 16'(both_low), 16'd0);
    chk("readys_both_high", 16'(both_ready), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
